// File: rtl/gen_xifo_pkg.sv
// Shared types for the xifo buffer family.
// Mode string decode and pointer width helper.
package gen_xifo_pkg;

  typedef enum logic {
    XIFO_FIFO = 1'b0,
    XIFO_LIFO = 1'b1
  } xifo_mode_e;

  function automatic xifo_mode_e xifo_mode(
    input logic [31:0] m
  );
    return (m == "LIFO") ? XIFO_LIFO : XIFO_FIFO;
  endfunction

  function automatic int unsigned clog2_min1(
    input int unsigned n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gen_mxifo_chan.sv
// One channel of gen_mxifo: storage, pointers, count and flags.
// FIFO uses wrap-around pointers; LIFO indexes storage by count.
module gen_mxifo_chan
  import gen_xifo_pkg::*;
#(
  parameter int         Depth        = 8,
  parameter int         DWidth       = 32,
  parameter xifo_mode_e ModeE        = XIFO_FIFO,
  parameter int         AFullThresh  = 6,
  parameter int         AEmptyThresh = 1,
  parameter int         CntW         = $clog2(Depth + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DWidth-1:0] data_in,
  output logic [DWidth-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              afull,
  output logic              aempty,
  output logic [CntW-1:0]   count
);

  localparam int PtrW = clog2_min1(Depth);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [DWidth-1:0] mem [Depth];
  logic [PtrW-1:0]   rd_ptr;
  logic [PtrW-1:0]   wr_ptr;
  logic [PtrW-1:0]   rd_idx;
  logic [PtrW-1:0]   wr_idx;
  logic [CntW-1:0]   cnt;
  logic              push_ok;
  logic              pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(
    input logic [PtrW-1:0] p
  );
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign full   = (cnt == CntW'(Depth));
  assign empty  = (cnt == '0);
  assign afull  = (cnt >= CntW'(AFullThresh));
  assign aempty = (cnt <= CntW'(AEmptyThresh));
  assign count  = cnt;

  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;

  // LIFO push with a same-cycle pop overwrites the current top
  always_comb begin
    rd_idx = rd_ptr;
    wr_idx = wr_ptr;
    if (ModeE == XIFO_LIFO) begin
      rd_idx = PtrW'(cnt - 1'b1);
      wr_idx = pop_ok ? rd_idx : PtrW'(cnt);
    end
  end

  assign data_out = empty ? '0 : mem[rd_idx];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      cnt    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      cnt <= cnt + CntW'(push_ok) - CntW'(pop_ok);
      if (push_ok) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_idx] <= data_in;
    end
  end

endmodule

// File: rtl/gen_mxifo.sv
// Multi-channel FIFO/LIFO behind one push and one pop port.
// Sticky overflow/underflow flags only when GEN_MXIFO_ERR_EN is defined.
module gen_mxifo
  import gen_xifo_pkg::*;
#(
  parameter int          NumChan      = 4,
  parameter int          QueueDepth   = 8,
  parameter int          DWidth       = 32,
  parameter logic [31:0] Mode         = "FIFO",
  parameter int          AFullThresh  = 6,
  parameter int          AEmptyThresh = 1,
  parameter int          ChW          = clog2_min1(NumChan),
  parameter int          CntW         = $clog2(QueueDepth + 1)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    push,
  input  logic [ChW-1:0]          wr_chan,
  input  logic [DWidth-1:0]       data_in,
  input  logic                    pop,
  input  logic [ChW-1:0]          rd_chan,
  output logic [DWidth-1:0]       data_out,
  input  logic [NumChan-1:0]      flush,
  output logic [NumChan-1:0]      full,
  output logic [NumChan-1:0]      empty,
  output logic [NumChan-1:0]      afull,
  output logic [NumChan-1:0]      aempty,
  output logic [NumChan*CntW-1:0] count,
  output logic                    err_ovf,
  output logic                    err_unf
);

  localparam xifo_mode_e ModeE = xifo_mode(Mode);

  logic [NumChan-1:0] push_vec;
  logic [NumChan-1:0] pop_vec;
  logic [DWidth-1:0]  chan_dout [NumChan];

  for (genvar c = 0; c < NumChan; c++) begin : g_chan
    assign push_vec[c] = push & (wr_chan == ChW'(c));
    assign pop_vec[c]  = pop & (rd_chan == ChW'(c));

    gen_mxifo_chan #(
      .Depth       (QueueDepth),
      .DWidth      (DWidth),
      .ModeE       (ModeE),
      .AFullThresh (AFullThresh),
      .AEmptyThresh(AEmptyThresh),
      .CntW        (CntW)
    ) u_chan (
      .clk     (clk),
      .rstn    (rstn),
      .push    (push_vec[c]),
      .pop     (pop_vec[c]),
      .flush   (flush[c]),
      .data_in (data_in),
      .data_out(chan_dout[c]),
      .full    (full[c]),
      .empty   (empty[c]),
      .afull   (afull[c]),
      .aempty  (aempty[c]),
      .count   (count[c*CntW +: CntW])
    );
  end

  // Out-of-range rd_chan matches no channel and reads as zero
  always_comb begin
    data_out = '0;
    for (int c = 0; c < NumChan; c++) begin
      if (rd_chan == ChW'(c)) begin
        data_out = chan_dout[c];
      end
    end
  end

`ifdef GEN_MXIFO_ERR_EN
  logic ovf_evt;
  logic unf_evt;

  assign ovf_evt = |(push_vec & full);
  assign unf_evt = |(pop_vec & empty);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      err_ovf <= err_ovf | ovf_evt;
      err_unf <= err_unf | unf_evt;
    end
  end
`else
  assign err_ovf = 1'b0;
  assign err_unf = 1'b0;
`endif

endmodule
